conv_encoder_k7: RTL and testbench

- Streaming rate-1/2, constraint-length-7 convolutional encoder. It is the transmit-side counterpart of the 64-state Viterbi decoder (BMC/ACS/traceback).
- Accepts one information bit per handshake and emits one coded pair per handshake.
- At each frame end it appends K-1 zero tail bits, so the decoder's trellis terminates in state 0.
- Its coded-pair bit ordering is the same as the decoder's rx_pair input.

---
 rtl/conv_code_pkg.sv | 18 +
 rtl/conv_pair_gen.sv | 16 +
 rtl/conv_encoder_k7.sv | 119 +++++++++++
 tb/tb_conv_encoder_k7.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_code_pkg.sv
// Shared constants and types for the K=7 rate-1/2 convolutional code.
// Used by the encoder here and by the Viterbi decoder's BMC/ACS stages.
package conv_code_pkg;

  localparam int K_DEF = 7;
  localparam logic [K_DEF-1:0] G0_DEF = 7'o171;
  localparam logic [K_DEF-1:0] G1_DEF = 7'o133;
  localparam int NSTATE = 1 << (K_DEF - 1);

  typedef logic [K_DEF-2:0] state_t;
  typedef logic [1:0]       pair_t;

  typedef enum logic {
    DATA = 1'b0,
    TAIL = 1'b1
  } enc_fsm_t;

endpackage

// File: rtl/conv_pair_gen.sv
// Parity reduction for one trellis branch: encoding word w -> coded pair {G1, G0}.
// w[K-1] is the bit being encoded; w[K-2:0] is the shift-register state.
module conv_pair_gen
  import conv_code_pkg::*;
#(
  parameter int             K  = K_DEF,
  parameter logic [K-1:0]   G0 = G0_DEF,
  parameter logic [K-1:0]   G1 = G1_DEF
) (
  input  logic [K-1:0] w,
  output pair_t        pair
);

  assign pair = {^(w & G1), ^(w & G0)};

endmodule

// File: rtl/conv_encoder_k7.sv
// Streaming rate-1/2 K=7 convolutional encoder with optional zero-tail
// termination so each frame's trellis ends in state 0.
module conv_encoder_k7
  import conv_code_pkg::*;
#(
  parameter int           K       = K_DEF,
  parameter logic [K-1:0] G0      = G0_DEF,
  parameter logic [K-1:0] G1      = G1_DEF,
  parameter bit           TAIL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] out_pair,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
);

  localparam int             CW        = $clog2(K);
  localparam logic [CW-1:0]  TAIL_LAST = CW'(K - 2);

  enc_fsm_t      state, state_next;
  logic [CW-1:0] tail_cnt, tail_cnt_next;
  logic [K-2:0]  sr;
  logic          slot_free;
  logic          accept;
  logic          load;
  logic          last_next;
  logic          enc_bit;
  logic [K-1:0]  w;
  pair_t         pair;

  assign slot_free = !out_valid || out_ready;
  // Gated by rst so the upstream sees no ready while the block is held in reset.
  assign in_ready  = !rst && (state == DATA) && slot_free;
  assign accept    = in_valid && in_ready;
  assign enc_bit   = (state == DATA) && in_bit;
  assign w         = {enc_bit, sr};
  assign busy      = (state == TAIL) || out_valid;

  conv_pair_gen #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_pair_gen (
    .w    (w),
    .pair (pair)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    tail_cnt_next = tail_cnt;
    load          = 1'b0;
    last_next     = 1'b0;
    unique case (state)
      DATA: begin
        if (accept) begin
          load = 1'b1;
          if (in_last) begin
            if (TAIL_EN) begin
              state_next    = TAIL;
              tail_cnt_next = '0;
            end else begin
              last_next = 1'b1;
            end
          end
        end
      end
      TAIL: begin
        if (slot_free) begin
          load = 1'b1;
          if (tail_cnt == TAIL_LAST) begin
            last_next     = 1'b1;
            state_next    = DATA;
            tail_cnt_next = '0;
          end else begin
            tail_cnt_next = tail_cnt + 1'b1;
          end
        end
      end
      default: state_next = DATA;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DATA;
      tail_cnt <= '0;
    end else begin
      state    <= state_next;
      tail_cnt <= tail_cnt_next;
    end
  end

  // sr only advances together with a pair load, so a stalled output freezes the trellis.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr        <= '0;
      out_pair  <= 2'b00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      sr        <= w[K-1:1];
      out_pair  <= pair;
      out_valid <= 1'b1;
      out_last  <= last_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_encoder_k7.sv
// Self-checking bench for conv_encoder_k7: random and directed frames scored
// against a tap-sum reference encoder working on the plain input-bit history.
module tb_conv_encoder_k7;
  import conv_code_pkg::*;

  localparam int           K  = K_DEF;
  localparam logic [K-1:0] G0 = G0_DEF;
  localparam logic [K-1:0] G1 = G1_DEF;

  typedef struct {
    logic [1:0] pair;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_bit = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic       in_ready, out_valid, out_last, busy;
  logic [1:0] out_pair;
  logic       n_in_bit = 1'b0, n_in_valid = 1'b0, n_in_last = 1'b0, n_out_ready = 1'b1;
  logic       n_in_ready, n_out_valid, n_out_last, n_busy;
  logic [1:0] n_out_pair;

  always #5 clk = ~clk;

  conv_encoder_k7 #(.TAIL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_pair(out_pair), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  conv_encoder_k7 #(.TAIL_EN(1'b0)) dut_nt (
    .clk(clk), .rst(rst), .in_bit(n_in_bit), .in_valid(n_in_valid), .in_last(n_in_last),
    .in_ready(n_in_ready), .out_pair(n_out_pair), .out_valid(n_out_valid), .out_last(n_out_last),
    .out_ready(n_out_ready), .busy(n_busy)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cycle    = 0;
  bit         hist[$];
  bit         hist2[$];
  exp_t       expq[$];
  exp_t       expq2[$];
  logic [1:0] got_pair[$];
  logic       got_last[$];
  int         got_cyc[$];
  logic       hold_pending = 1'b0;
  logic [2:0] held;
  logic       accepted;
  logic       ready_s;
  logic [1:0] imp [7] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Pair for the newest bit of h: XOR of generator taps over the last K inputs.
  function automatic logic [1:0] ref_encode(input bit h[$]);
    int s0 = 0;
    int s1 = 0;
    int n  = h.size();
    logic [1:0] r;
    for (int d = 0; d < K; d++) begin
      if (n - 1 - d >= 0 && h[n-1-d]) begin
        s0 += int'(G0[K-1-d]);
        s1 += int'(G1[K-1-d]);
      end
    end
    r[0] = (s0 % 2) == 1;
    r[1] = (s1 % 2) == 1;
    return r;
  endfunction

  task automatic model_accept(input bit b, input bit last);
    hist.push_back(b);
    expq.push_back('{ref_encode(hist), 1'b0});
    if (last) begin
      for (int t = 0; t < K - 1; t++) begin
        hist.push_back(1'b0);
        expq.push_back('{ref_encode(hist), (t == K - 2)});
      end
      hist.delete();
    end
  endtask

  task automatic clear_log();
    got_pair.delete();
    got_last.delete();
    got_cyc.delete();
  endtask

  // One clock: drive at the falling edge, sample 1 ns later; the sampled
  // handshakes are the ones the next rising edge will perform.
  task automatic step(input logic v, input logic b, input logic l, input logic r);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_bit = b; in_last = l; out_ready = r;
    #1;
    cycle++;
    if (hold_pending) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'({out_last, out_pair}), 32'(held));
    end
    hold_pending = out_valid && !out_ready;
    held         = {out_last, out_pair};
    ready_s      = in_ready;
    accepted     = in_valid && in_ready;
    if (accepted) model_accept(in_bit, in_last);
    if (out_valid && out_ready) begin
      got_pair.push_back(out_pair);
      got_last.push_back(out_last);
      got_cyc.push_back(cycle);
      if (expq.size() == 0) begin
        check("extra_pair", 32'd1, 32'd0);
      end else begin
        e = expq.pop_front();
        check("pair", 32'(out_pair), 32'(e.pair));
        check("last", 32'(out_last), 32'(e.last));
      end
    end
  endtask

  task automatic send_frame(input bit bits[$], input bit rnd);
    logic v, r;
    int   tries;
    foreach (bits[i]) begin
      tries = 0;
      do begin
        v = rnd ? 1'($urandom_range(0, 3) != 0) : 1'b1;
        r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        step(v, bits[i], (i == bits.size() - 1), r);
        tries++;
      end while (!accepted && tries < 100);
      if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || out_valid) && n < 200) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    check("drain_pending", 32'(expq.size()), 32'd0);
  endtask

  task automatic check_impulse(input string tag);
    check({tag, "_count"}, 32'(got_pair.size()), 32'd7);
    for (int i = 0; i < 7 && i < got_pair.size(); i++) begin
      check({tag, "_pair"}, 32'(got_pair[i]), 32'(imp[i]));
      check({tag, "_last"}, 32'(got_last[i]), 32'(i == 6));
      check({tag, "_cyc"}, 32'(got_cyc[i]), 32'(got_cyc[0] + i));
    end
  endtask

  task automatic step_nt(input logic v, input logic b, input logic l);
    exp_t e;
    @(negedge clk);
    n_in_valid = v; n_in_bit = b; n_in_last = l; n_out_ready = 1'b1;
    #1;
    if (n_out_valid) begin
      got_pair.push_back(n_out_pair);
      got_last.push_back(n_out_last);
      if (expq2.size() == 0) begin
        check("nt_extra_pair", 32'd1, 32'd0);
      end else begin
        e = expq2.pop_front();
        check("nt_pair", 32'(n_out_pair), 32'(e.pair));
        check("nt_last", 32'(n_out_last), 32'(e.last));
      end
    end
    if (n_in_valid && n_in_ready) begin
      hist2.push_back(b);
      expq2.push_back('{ref_encode(hist2), l});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit frame[$];
    int low, n;

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pair", 32'(out_pair), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Impulse response
    clear_log();
    frame = '{1'b1};
    send_frame(frame, 1'b0);
    drain();
    check_impulse("impulse");

    // All-zero frame of 10 bits, in_ready low during the 6 tail cycles
    clear_log();
    frame = '{};
    for (int i = 0; i < 10; i++) frame.push_back(1'b0);
    send_frame(frame, 1'b0);
    low = 0;
    n   = 0;
    do begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if (!ready_s) low++;
      n++;
    end while (!ready_s && n < 20);
    check("zero_ready_low", 32'(low), 32'(K - 1));
    drain();
    check("zero_count", 32'(got_pair.size()), 32'd16);
    for (int i = 0; i < got_pair.size(); i++) begin
      check("zero_pair", 32'(got_pair[i]), 32'd0);
      check("zero_last", 32'(got_last[i]), 32'(i == 15));
    end

    // Random 100-bit frame under random backpressure
    clear_log();
    frame = '{};
    for (int i = 0; i < 100; i++) frame.push_back(1'($urandom_range(0, 1)));
    send_frame(frame, 1'b1);
    drain();
    check("bp_count", 32'(got_pair.size()), 32'd106);

    // Back-to-back frames {1,0,1} and {1,1}
    clear_log();
    frame = '{1'b1, 1'b0, 1'b1};
    send_frame(frame, 1'b0);
    frame = '{1'b1, 1'b1};
    send_frame(frame, 1'b0);
    drain();
    check("b2b_count", 32'(got_pair.size()), 32'd17);
    if (got_pair.size() == 17) begin
      check("b2b_last1", 32'(got_last[8]), 32'd1);
      check("b2b_last2", 32'(got_last[16]), 32'd1);
      check("b2b_first2", 32'(got_pair[9]), 32'd3);
      for (int i = 1; i < 17; i++)
        check("b2b_no_bubble", 32'(got_cyc[i]), 32'(got_cyc[i-1] + 1));
    end

    // Reset asserted mid-tail with a pair held on the output
    clear_log();
    frame = '{1'b1, 1'b1, 1'b0};
    send_frame(frame, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_last", 32'(out_last), 32'd0);
    expq.delete();
    hist.delete();
    hold_pending = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    frame = '{1'b1};
    send_frame(frame, 1'b0);
    drain();
    check_impulse("post_rst");

    // No-tail build: frame {1}, then bit 0 shows retained state, then random bits
    clear_log();
    step_nt(1'b1, 1'b1, 1'b1);
    step_nt(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      step_nt(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    step_nt(1'b0, 1'b0, 1'b0);
    step_nt(1'b0, 1'b0, 1'b0);
    check("nt_count", 32'(got_pair.size()), 32'd22);
    if (got_pair.size() >= 2) begin
      check("nt_first_pair", 32'(got_pair[0]), 32'd3);
      check("nt_first_last", 32'(got_last[0]), 32'd1);
      check("nt_second_pair", 32'(got_pair[1]), 32'd1);
      check("nt_second_last", 32'(got_last[1]), 32'd0);
    end
    check("nt_pending", 32'(expq2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
